// File: rtl/csa_multiword_sequencer_if.sv
// Request/result handshake and shared 8-bit adder slice bus for csa_multiword_sequencer.
// CSA_SEQ_SUB_EN adds the in_sub request field.
interface csa_multiword_sequencer_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
`ifdef CSA_SEQ_SUB_EN
   logic         in_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;
   logic [7:0]   adder_a;
   logic [7:0]   adder_b;
   logic         adder_cin;
   logic [7:0]   adder_y;
   logic         adder_cout;

   // master: requester, result consumer and the external adder slice
   modport master (
      output in_valid, in_a, in_b, in_cin,
`ifdef CSA_SEQ_SUB_EN
      output in_sub,
`endif
      output out_ready, adder_y, adder_cout,
      input  in_ready, out_valid, out_sum, out_cout, busy,
      input  adder_a, adder_b, adder_cin
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin,
`ifdef CSA_SEQ_SUB_EN
      input  in_sub,
`endif
      input  out_ready, adder_y, adder_cout,
      output in_ready, out_valid, out_sum, out_cout, busy,
      output adder_a, adder_b, adder_cin
   );
endinterface

// File: rtl/csa_multiword_sequencer.sv
// Multi-precision add controller time-sharing one external 8-bit adder, LSB byte first.
// Optional CSA_SEQ_SUB_EN: subtract mode (A - B) selected per request by in_sub.
module csa_multiword_sequencer #(
   parameter int NBYTES = 4
) (
   input logic                     clk,
   input logic                     rst,
   csa_multiword_sequencer_if.slave bus
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            sub_q, sub_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      sub_d   = sub_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef CSA_SEQ_SUB_EN
               // two's-complement subtract: invert B bytes, inject +1 at byte 0
               sub_d   = bus.in_sub;
               carry_d = bus.in_sub | bus.in_cin;
`else
               sub_d   = 1'b0;
               carry_d = bus.in_cin;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[8*idx_q +: 8] = bus.adder_y;
            carry_d = bus.adder_cout;
            if (idx_q == LAST) begin
               cout_d  = bus.adder_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !rst;
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.out_sum   = sum_q;
      bus.out_cout  = cout_q;
      bus.adder_a   = 8'h00;
      bus.adder_b   = 8'h00;
      bus.adder_cin = 1'b0;
      if (state_q == RUN) begin
         bus.adder_a   = a_q[8*idx_q +: 8];
         bus.adder_b   = b_q[8*idx_q +: 8] ^ {8{sub_q}};
         bus.adder_cin = carry_q;
      end
   end
endmodule

// File: tb/tb_csa_multiword_sequencer.sv
// Directed self-checking bench for csa_multiword_sequencer (NBYTES=4) with a behavioural 8-bit adder.
module tb_csa_multiword_sequencer;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   csa_multiword_sequencer_if #(.NBYTES(NB)) bus ();

   csa_multiword_sequencer #(.NBYTES(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // external adder slice
   assign {bus.adder_cout, bus.adder_y} =
      {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {8'h00, bus.adder_cin};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_sub(input logic s);
`ifdef CSA_SEQ_SUB_EN
      bus.in_sub = s;
`else
      if (s) chk("sub_not_built", 64'd1, 64'd0);
`endif
   endtask

   // one full operation with out_ready=1; checks latency, byte sequence and result
   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sub,
                     input logic [31:0] es, input logic ec);
      int n;
      logic [31:0] av;
      av = a;
      n  = 0;
      while (!bus.in_ready && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.out_ready = 1'b1;
      set_sub(sub);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      bus.in_a = ~a;
      bus.in_b = ~b;
      chk({tag, "_cin0"}, 64'(bus.adder_cin), 64'(sub | cin));
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_adder_a%0d", tag, i), 64'(bus.adder_a), 64'(av[8*i +: 8]));
         chk($sformatf("%s_early%0d", tag, i), 64'(bus.out_valid), 64'd0);
         step();
      end
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
      chk({tag, "_cout"}, 64'(bus.out_cout), 64'(ec));
      step();
      chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
      bus.out_ready = 1'b0;
      set_sub(1'b0);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
      chk("rst_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
      step(); step();
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

      op("inc",    32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
      op("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1);
      op("msb",    32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1);
      op("mixed",  32'h0001FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00020000, 1'b0);

      // backpressure, ignored in_valid in RUN/DONE, then back-to-back accept
      bus.in_a = 32'h12345678; bus.in_b = 32'h11111111; bus.in_cin = 1'b0;
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      step();
      bus.in_a = 32'hDEADBEEF; bus.in_b = 32'h0;
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("bp_run_ready%0d", i), 64'(bus.in_ready), 64'd0);
         bus.in_valid = i[0];
         step();
      end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         chk($sformatf("bp_valid%0d", i), 64'(bus.out_valid), 64'd1);
         chk($sformatf("bp_sum%0d", i), 64'(bus.out_sum), 64'h23456789);
         chk($sformatf("bp_ready%0d", i), 64'(bus.in_ready), 64'd0);
         step();
      end
      bus.in_a = 32'd3; bus.in_b = 32'd4; bus.out_ready = 1'b1;
      chk("bp_hs_valid", 64'(bus.out_valid), 64'd1);
      step();
      chk("b2b_idle_valid", 64'(bus.out_valid), 64'd0);
      chk("b2b_idle_ready", 64'(bus.in_ready), 64'd1);
      chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
      step();
      bus.in_valid = 1'b0;
      chk("b2b_accept_busy", 64'(bus.busy), 64'd1);
      chk("b2b_adder_a", 64'(bus.adder_a), 64'h03);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("b2b_early%0d", i), 64'(bus.out_valid), 64'd0);
         step();
      end
      chk("b2b_valid", 64'(bus.out_valid), 64'd1);
      chk("b2b_sum", 64'(bus.out_sum), 64'd7);
      step();

      // reset while idx=2
      bus.in_a = 32'hAABBCCDD; bus.in_b = 32'h01010101; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step(); step();
      chk("mid_adder_a_idx2", 64'(bus.adder_a), 64'hBB);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
      chk("mid_rst_sum", 64'(bus.out_sum), 64'd0);
      chk("mid_rst_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("mid_rst_no_valid%0d", i), 64'(bus.out_valid), 64'd0);
      end
      rst = 1'b0;
      op("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'h00000007, 1'b0);

`ifdef CSA_SEQ_SUB_EN
      op("sub_neg", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
      op("sub_eq",  32'h00000010, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b1);
      set_sub(1'b0);
      op("add_after_sub", 32'h00000010, 32'h00000010, 1'b0, 1'b0, 32'h00000020, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
